// File: rtl/mmio_input_ctrl.sv
// mmio_input_ctrl: memory-mapped debounced input channels with sticky edge flags, irq mask and press counter
// Ports:
//   clock         sole clock, rising edge
//   reset         asynchronous, active-low
//   btn_in        raw asynchronous channel inputs
//   address_dmem  processor data word address
//   wren          processor write enable
//   data          processor write data
//   q_dmem        registered read data (0 when not selected)
//   sel_q         registered: q_dmem comes from this block this cycle
//   irq           registered: any EDGE & MASK bit set
module mmio_input_ctrl #(
    parameter int          NUM_CH          = 4,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR       = 32'd1000,
    parameter int          CNT_W           = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic [31:0]       address_dmem,
    input  logic              wren,
    input  logic [31:0]       data,
    output logic [31:0]       q_dmem,
    output logic              sel_q,
    output logic              irq
);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] CMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT = '1;

    logic [NUM_CH-1:0] sync1, sync2, level, edge_r, mask, flip, rise, clr;
    logic [DW-1:0]     cnt [NUM_CH];
    logic [CNT_W-1:0]  count, count_base, count_n;
    logic [31:0]       off, rdata;
    logic [5:0]        pop;
    logic [32:0]       sum;
    logic              hit, we, unused_data;

    always_comb begin
        // Unsigned wrap makes this an exact match on BASE_ADDR..BASE_ADDR+3 only.
        off = address_dmem - BASE_ADDR;
        hit = off < 32'd4;
        we = wren && hit;
        unused_data = ^data;
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            flip[i] = sync2[i] != level[i] && cnt[i] == CMAX;
            pop = pop + 6'(flip[i] & sync2[i]);
        end
        rise = flip & sync2;
        clr = (we && off[1:0] == 2'd1) ? data[NUM_CH-1:0] : '0;
        // A COUNT write restarts from this cycle's presses so none are lost.
        count_base = (we && off[1:0] == 2'd3) ? '0 : count;
        sum = 33'(count_base) + 33'(pop);
        count_n = sum > 33'(SAT) ? SAT : sum[CNT_W-1:0];
        rdata = off[1:0] == 2'd0 ? 32'(level) :
                off[1:0] == 2'd1 ? 32'(edge_r) :
                off[1:0] == 2'd2 ? 32'(mask) : 32'(count);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            level  <= '0;
            edge_r <= '0;
            mask   <= '0;
            count  <= '0;
            q_dmem <= '0;
            sel_q  <= 1'b0;
            irq    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            for (int i = 0; i < NUM_CH; i++)
                cnt[i] <= (sync2[i] == level[i] || flip[i]) ? '0 : cnt[i] + DW'(1);
            level  <= level ^ flip;
            // A rise in the same cycle as its clear keeps the flag set.
            edge_r <= (edge_r & ~clr) | rise;
            if (we && off[1:0] == 2'd2) mask <= data[NUM_CH-1:0];
            count  <= count_n;
            irq    <= |(edge_r & mask);
            sel_q  <= hit && !wren;
            q_dmem <= (hit && !wren) ? rdata : '0;
        end
    end
endmodule

// File: tb/tb_mmio_input_ctrl.sv
// tb_mmio_input_ctrl: directed bench for mmio_input_ctrl (default and 2-bit counter instances)
module tb_mmio_input_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  btn_in = '0;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem, q2;
    logic        sel_q, sel2, irq, irq2;
    int          n = 0;
    int          errs = 0;

    mmio_input_ctrl dut (
        .clock(clock), .reset(reset), .btn_in(btn_in), .address_dmem(address_dmem),
        .wren(wren), .data(data), .q_dmem(q_dmem), .sel_q(sel_q), .irq(irq)
    );

    mmio_input_ctrl #(.CNT_W(2)) sat (
        .clock(clock), .reset(reset), .btn_in(btn_in), .address_dmem(address_dmem),
        .wren(wren), .data(data), .q_dmem(q2), .sel_q(sel2), .irq(irq2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        sel;
        logic [31:0] q;
        logic        irq;
    } vec_t;

    vec_t v [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic rd(input logic [31:0] a);
        address_dmem = a;
        wren = 1'b0;
        @(negedge clock);
        address_dmem = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address_dmem = a;
        data = d;
        wren = 1'b1;
        @(negedge clock);
        wren = 1'b0;
        data = '0;
        address_dmem = '0;
    endtask

    initial begin
        v[0]  = '{32'd1000, 1'b0, 32'h0,        1'b1, 32'hF, 1'b0};
        v[1]  = '{32'd1001, 1'b0, 32'h0,        1'b1, 32'h9, 1'b0};
        v[2]  = '{32'd1002, 1'b0, 32'h0,        1'b1, 32'h0, 1'b0};
        v[3]  = '{32'd1003, 1'b0, 32'h0,        1'b1, 32'h2, 1'b0};
        v[4]  = '{32'd1004, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0};
        v[5]  = '{32'd999,  1'b0, 32'h0,        1'b0, 32'h0, 1'b0};
        v[6]  = '{32'd1002, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0};
        v[7]  = '{32'd1002, 1'b0, 32'h0,        1'b1, 32'hF, 1'b1};
        v[8]  = '{32'd1001, 1'b1, 32'h1,        1'b0, 32'h0, 1'b1};
        v[9]  = '{32'd1001, 1'b0, 32'h0,        1'b1, 32'h8, 1'b1};
        v[10] = '{32'd1001, 1'b0, 32'h0,        1'b1, 32'h8, 1'b1};
        v[11] = '{32'd1003, 1'b1, 32'h0,        1'b0, 32'h0, 1'b1};
        v[12] = '{32'd1003, 1'b0, 32'h0,        1'b1, 32'h0, 1'b1};
        v[13] = '{32'd1000, 1'b1, 32'h0,        1'b0, 32'h0, 1'b1};
        v[14] = '{32'd1000, 1'b0, 32'h0,        1'b1, 32'hF, 1'b1};
        v[15] = '{32'd0,    1'b0, 32'h0,        1'b0, 32'h0, 1'b1};

        tick(2);
        chk("rst_q", q_dmem, 0);
        chk("rst_sel", 32'(sel_q), 0);
        chk("rst_irq", 32'(irq), 0);
        reset = 1'b1;
        rd(32'd1001); chk("rst_edge", q_dmem, 0);
        rd(32'd1003); chk("rst_count", q_dmem, 0);

        btn_in[0] = 1'b1;
        tick(5);
        rd(32'd1000); chk("lvl_at_5", q_dmem, 0);
        rd(32'd1000); chk("lvl_at_6", q_dmem, 1);
        chk("lvl_sel", 32'(sel_q), 1);
        rd(32'd1001); chk("press_edge", q_dmem, 1);
        rd(32'd1003); chk("press_count", q_dmem, 1);
        chk("press_count_sat", q2, 1);

        btn_in[1] = 1'b1;
        tick(3);
        btn_in[1] = 1'b0;
        tick(8);
        rd(32'd1000); chk("glitch_lvl", q_dmem, 1);
        rd(32'd1001); chk("glitch_edge", q_dmem, 1);
        rd(32'd1003); chk("glitch_count", q_dmem, 1);

        btn_in[0] = 1'b0;
        tick(8);
        btn_in[1] = 1'b1;
        tick(8);
        rd(32'd1001); chk("edge_11", q_dmem, 32'h3);
        rd(32'd1000); chk("lvl_fall", q_dmem, 32'h2);
        btn_in[0] = 1'b1;
        tick(5);
        wr(32'd1001, 32'h1);
        rd(32'd1001); chk("w1c_race", q_dmem, 32'h3);
        rd(32'd1000); chk("race_lvl", q_dmem, 32'h3);
        wr(32'd1001, 32'h3);
        rd(32'd1001); chk("w1c_clear", q_dmem, 32'h0);

        wr(32'd1002, 32'h4);
        btn_in[2] = 1'b1;
        tick(6);
        chk("irq_same_cycle", 32'(irq), 0);
        tick(1);
        chk("irq_rise", 32'(irq), 1);
        wr(32'd1002, 32'h0);
        chk("irq_mask_hold", 32'(irq), 1);
        tick(1);
        chk("irq_masked", 32'(irq), 0);
        wr(32'd1001, 32'h4);
        rd(32'd1001); chk("edge2_clear", q_dmem, 32'h0);
        rd(32'd1003); chk("count_4", q_dmem, 32'd4);

        btn_in[0] = 1'b0;
        tick(8);
        btn_in[0] = 1'b1;
        tick(8);
        rd(32'd1003);
        chk("count_5", q_dmem, 32'd5);
        chk("count_saturated", q2, 32'd3);
        btn_in[0] = 1'b0;
        tick(8);
        btn_in = btn_in | 4'b1001;
        tick(5);
        wr(32'd1003, 32'h0);
        rd(32'd1003);
        chk("count_clear_race", q_dmem, 32'd2);
        chk("count_clear_race_sat", q2, 32'd2);

        for (int i = 0; i < 16; i++) begin
            address_dmem = v[i].addr;
            wren = v[i].wr;
            data = v[i].wdata;
            @(negedge clock);
            chk($sformatf("vec%0d_q", i), q_dmem, v[i].q);
            chk($sformatf("vec%0d_sel", i), 32'(sel_q), 32'(v[i].sel));
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(v[i].irq));
        end
        wren = 1'b0;
        data = '0;
        address_dmem = '0;

        btn_in = '0;
        tick(8);
        btn_in[1] = 1'b1;
        tick(8);
        btn_in[0] = 1'b1;
        address_dmem = 32'd1000;
        tick(3);
        chk("pre_rst_q", q_dmem, 32'h2);
        chk("pre_rst_sel", 32'(sel_q), 1);
        chk("pre_rst_irq", 32'(irq), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_q", q_dmem, 0);
        chk("async_rst_sel", 32'(sel_q), 0);
        chk("async_rst_irq", 32'(irq), 0);
        @(negedge clock);
        address_dmem = '0;
        reset = 1'b1;
        tick(5);
        rd(32'd1000); chk("post_rst_lvl_5", q_dmem, 0);
        rd(32'd1000); chk("post_rst_lvl_6", q_dmem, 32'h3);
        rd(32'd1001); chk("post_rst_edge", q_dmem, 32'h3);
        rd(32'd1003); chk("post_rst_count", q_dmem, 32'd2);
        rd(32'd1002); chk("post_rst_mask", q_dmem, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/mmio_input_ctrl.md
# mmio_input_ctrl

Memory-mapped input controller for the processor data bus. It replaces the single hard-wired button at data address 1000 with NUM_CH synchronised, debounced input channels. It also provides sticky rising-edge flags, an interrupt mask and a saturating press counter. It sits beside RAM on the dmem bus, and its registered select output steers the q_dmem read mux.

## Interface
- NUM_CH, 4: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to flip a debounced level, ≥1.
- BASE_ADDR, 1000: word address of register 0; the block occupies BASE_ADDR..BASE_ADDR+3.
- CNT_W, 16: press counter width, 1..32.

- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- btn_in  in  NUM_CH  raw asynchronous channel inputs.
- address_dmem  in  32  processor data address.
- wren  in  1  processor data write enable.
- data  in  32  processor write data.
- q_dmem  out  32  registered read data.
- sel_q  out  1  registered flag: q_dmem is valid from this block this cycle, and the bus mux takes it over RAM.
- irq  out  1  high when any (EDGE & MASK) bit is set.

## Operation
- Register map, word offsets from BASE_ADDR:
  - +0 LEVEL (RO): debounced levels.
  - +1 EDGE (W1C): sticky rising-edge flags.
  - +2 MASK (RW): irq enables.
  - +3 COUNT (RO, any write clears): press counter.
  - Bits ≥NUM_CH (≥CNT_W for COUNT) read 0 and ignore writes.
- Decode: hit = (address_dmem == BASE_ADDR+k) for k in 0..3, full 32-bit compare. Out-of-range addresses are ignored.
- Synchroniser: two flops per channel, sync = stage-2 output.
- Debounce, per channel:
  - Counter cnt clears while sync == level.
  - While sync != level, cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and sync != level, level <= sync and cnt <= 0.
  - A single-cycle glitch shorter than DEBOUNCE_CYCLES never flips level.
- Rise event: rise[i] = level flips 0→1 this cycle. Falling transitions update LEVEL only.
- EDGE update: EDGE <= (EDGE & ~clr) | rise, where clr = data[NUM_CH-1:0] on a write to +1. A set in the same cycle as its clear wins (bit stays 1).
- COUNT update:
  - COUNT <= sat(COUNT + popcount(rise)), saturating at 2^CNT_W-1, never wrapping.
  - On a write to +3, COUNT <= popcount(rise) instead (events in the clear cycle are not lost).
- MASK: written on wren to +2; the new value affects irq the following cycle.
- Reads, any cycle with hit and !wren: q_dmem <= selected register value, sel_q <= 1. Otherwise sel_q <= 0 and q_dmem <= 0.
- A read of EDGE does not clear it.
- Reset: all flops clear asynchronously. LEVEL, EDGE, MASK, COUNT, debounce counters, synchronisers, q_dmem, sel_q and irq all go to 0. Releasing reset mid-press restarts debouncing from level 0.

## Timing
- Input latency: a clean btn_in edge appears in LEVEL after 2 (sync) + DEBOUNCE_CYCLES clocks. EDGE/COUNT update on that same clock edge.
- Read latency: 1 cycle. The address is presented in cycle N, and q_dmem/sel_q are valid in cycle N+1, matching RAM dataOut timing.
- Write takes effect on the rising edge where wren && hit. A read in the next cycle returns the new value.
- irq is registered. It rises 1 cycle after the EDGE bit it reflects is set, and falls 1 cycle after that bit is cleared or masked.
- No handshake stall; the block accepts one access per cycle back-to-back.

## Test plan
- Debounce, with NUM_CH=4 and DEBOUNCE_CYCLES=4:
  - btn_in[0] 0→1 held → LEVEL reads 4'b0001 exactly 6 clocks after the edge, EDGE=4'b0001, COUNT=1.
  - A 3-cycle pulse on btn_in[1] → LEVEL, EDGE and COUNT stay unchanged.
- W1C race: EDGE=4'b0011, write 32'h1 to 1001 in the same cycle as a rise on ch0 → EDGE stays 4'b0011. A later write of 32'h3 with no rise → EDGE=0.
- irq: MASK=4'b0100, rise on ch2 → irq=1 one cycle after EDGE[2] sets. Write MASK=0 → irq=0 one cycle later. Write 32'h4 to 1001 → EDGE[2]=0.
- Counter:
  - With CNT_W=2, 5 presses → COUNT=3 (saturated).
  - Write to 1003 in a cycle where ch0 and ch3 rise simultaneously → COUNT=2.
- Bus:
  - Read 1000 in cycle N → sel_q=1 and q_dmem=LEVEL in N+1.
  - Read 1004 or 999 → sel_q=0, q_dmem=0.
  - Write 32'hFFFFFFFF to 1002 → MASK reads 32'h0000000F.
- Reset: assert reset=0 asynchronously mid-debounce with EDGE and COUNT nonzero → all outputs 0 immediately. After release, a held input reaches LEVEL after a full 6 clocks.
